// File: rtl/wheel_encoder_decoder_if.sv
// Encoder pins, clear strobe and measurement outputs of the wheel encoder reader.
// master drives the encoder and clear; slave is the decoder side.
interface wheel_encoder_decoder_if #(
    parameter int CNT_W = 16
);
    logic             encA;
    logic             encB;
    logic             clear;
    logic [CNT_W-1:0] position;
    logic [CNT_W-1:0] tick_count;
    logic             direction;
    logic [1:0]       measSpeed;
    logic             sample_valid;
    logic             quad_error;

    modport master (
        output encA,
        output encB,
        output clear,
        input  position,
        input  tick_count,
        input  direction,
        input  measSpeed,
        input  sample_valid,
        input  quad_error
    );

    modport slave (
        input  encA,
        input  encB,
        input  clear,
        output position,
        output tick_count,
        output direction,
        output measSpeed,
        output sample_valid,
        output quad_error
    );
endinterface

// File: rtl/wheel_encoder_decoder.sv
// Quadrature wheel-encoder reader: position count, per-window tick count,
// direction and a 2-bit speed code on the same scale as the drive command.
module wheel_encoder_decoder #(
    parameter int CNT_W         = 16,
    parameter int WINDOW_CYCLES = 10_000_000,
    parameter int THRESH1       = 50,
    parameter int THRESH2       = 150,
    parameter int THRESH3       = 300
) (
    input logic                    CLK100MHZ,
    input logic                    reset,
    wheel_encoder_decoder_if.slave bus
);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int ACC_W = CNT_W + 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {CNT_W{1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN =
        {1'b1, {(CNT_W-1){1'b0}}, 1'b1};

    localparam logic signed [ACC_W+1:0] WIDE_MAX = {2'b00, ACC_MAX};
    localparam logic signed [ACC_W+1:0] WIDE_MIN = {2'b11, ACC_MIN};

    localparam logic [CNT_W-1:0] T1 = CNT_W'(THRESH1);
    localparam logic [CNT_W-1:0] T2 = CNT_W'(THRESH2);
    localparam logic [CNT_W-1:0] T3 = CNT_W'(THRESH3);

    logic aMeta;
    logic aSync;
    logic bMeta;
    logic bSync;
    logic aPrev;
    logic bPrev;

    logic [CNT_W-1:0]        posQ;
    logic signed [ACC_W-1:0] acc;
    logic [WIN_W-1:0]        winCnt;
    logic [CNT_W-1:0]        tickQ;
    logic                    dirQ;
    logic [1:0]              speedQ;
    logic                    validQ;
    logic                    errQ;

    logic signed [1:0]       step;
    logic                    illegal;
    logic signed [ACC_W+1:0] accWide;
    logic signed [ACC_W-1:0] accSat;
    logic [CNT_W-1:0]        tickNext;
    logic [1:0]              speedNext;
    logic                    winEnd;

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            aMeta <= 1'b0;
            aSync <= 1'b0;
            bMeta <= 1'b0;
            bSync <= 1'b0;
            aPrev <= 1'b0;
            bPrev <= 1'b0;
        end else begin
            aMeta <= bus.encA;
            aSync <= aMeta;
            bMeta <= bus.encB;
            bSync <= bMeta;
            aPrev <= aSync;
            bPrev <= bSync;
        end
    end

    // Forward order is 00 -> 01 -> 11 -> 10 -> 00; both bits moving is illegal.
    always_comb begin
        step    = 2'sd0;
        illegal = 1'b0;
        unique case ({aPrev, bPrev, aSync, bSync})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step = 2'sd1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: step = -2'sd1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: step = 2'sd0;
        endcase
    end

    assign accWide = {{2{acc[ACC_W-1]}}, acc}
                   + {{ACC_W{step[1]}}, step};

    always_comb begin
        accSat = accWide[ACC_W-1:0];
        if (accWide > WIDE_MAX) begin
            accSat = ACC_MAX;
        end else if (accWide < WIDE_MIN) begin
            accSat = ACC_MIN;
        end
    end

    // accSat is bounded by +/-(2^CNT_W-1), so its magnitude fits CNT_W bits.
    assign tickNext = accSat[ACC_W-1] ? CNT_W'(-accSat) : CNT_W'(accSat);

    always_comb begin
        speedNext = 2'd3;
        if (tickNext < T1) begin
            speedNext = 2'd0;
        end else if (tickNext < T2) begin
            speedNext = 2'd1;
        end else if (tickNext < T3) begin
            speedNext = 2'd2;
        end
    end

    assign winEnd = (winCnt == WIN_LAST);

    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            posQ   <= '0;
            acc    <= '0;
            winCnt <= '0;
            tickQ  <= '0;
            dirQ   <= 1'b1;
            speedQ <= 2'd0;
            validQ <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            validQ <= 1'b0;
            if (bus.clear) begin
                posQ   <= '0;
                acc    <= '0;
                winCnt <= '0;
                errQ   <= 1'b0;
            end else begin
                posQ <= posQ + CNT_W'(step);
                if (illegal) begin
                    errQ <= 1'b1;
                end
                if (winEnd) begin
                    winCnt <= '0;
                    acc    <= '0;
                    tickQ  <= tickNext;
                    speedQ <= speedNext;
                    validQ <= 1'b1;
                    if (accSat[ACC_W-1]) begin
                        dirQ <= 1'b0;
                    end else if (accSat != '0) begin
                        dirQ <= 1'b1;
                    end
                end else begin
                    winCnt <= winCnt + WIN_W'(1);
                    acc    <= accSat;
                end
            end
        end
    end

    assign bus.position     = posQ;
    assign bus.tick_count   = tickQ;
    assign bus.direction    = dirQ;
    assign bus.measSpeed    = speedQ;
    assign bus.sample_valid = validQ;
    assign bus.quad_error   = errQ;
endmodule
